// File: rtl/deg_out_if.sv
// Producer-side handshake and record output of the DEG output packer.
// The slave modport is the packer's view; master is the producer/sink side.
interface deg_out_if #(
  parameter int DEG_DATA_WIDTH  = 64,
  parameter int MAGIC_NUM_WIDTH = 16
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [DEG_DATA_WIDTH-1:0]                 in_data;
  logic                                      out_enable;
  logic [DEG_DATA_WIDTH+MAGIC_NUM_WIDTH-1:0] out_data;
  logic [31:0]                               emit_count;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_enable, out_data, emit_count
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_enable, out_data, emit_count
  );
endinterface

// File: rtl/deg_out_packer.sv
// Buffers DEG records in a small FIFO and emits them tagged with a magic number,
// rate-limited by a gap counter, with optional heartbeat records when idle.
module deg_out_packer #(
  parameter int                         DEG_DATA_WIDTH  = 64,
  parameter int                         MAGIC_NUM_WIDTH = 16,
  parameter logic [MAGIC_NUM_WIDTH-1:0] MAGIC_NUM       = 16'hDE60,
  parameter logic [MAGIC_NUM_WIDTH-1:0] HB_MAGIC        = 16'hDEB0,
  parameter int                         DEPTH           = 4,
  parameter int                         GAP_CYCLES      = 0,
  parameter int                         HEARTBEAT       = 0
) (
  input logic       clock,
  input logic       reset,
  deg_out_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int IW = (HEARTBEAT > 0) ? $clog2(HEARTBEAT + 1) : 1;
  localparam int OW = DEG_DATA_WIDTH + MAGIC_NUM_WIDTH;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [IW-1:0] IDLE_MAX = IW'(HEARTBEAT);

  logic [DEG_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]               wr_ptr, rd_ptr;
  logic [GW-1:0]             gap_cnt;
  logic [IW-1:0]             idle_cnt;
  logic [63:0]               cyc;
  logic                      out_en_q;
  logic [OW-1:0]             out_data_q;
  logic [31:0]               emit_cnt_q;
  logic                      empty, full, push, data_emit, hb_emit, emit;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.in_ready = !full && !reset;
  assign push         = bus.in_valid && bus.in_ready;

  // Data always beats heartbeat: heartbeat additionally requires an empty FIFO.
  assign data_emit = !empty && (gap_cnt == '0);
  assign hb_emit   = (HEARTBEAT > 0) && (idle_cnt == IDLE_MAX) && empty && (gap_cnt == '0);
  assign emit      = data_emit || hb_emit;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      idle_cnt   <= '0;
      cyc        <= '0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      emit_cnt_q <= '0;
    end else begin
      cyc      <= cyc + 64'd1;
      out_en_q <= emit;
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (data_emit) rd_ptr <= rd_ptr + 1'b1;

      if (data_emit)    out_data_q <= {MAGIC_NUM, mem[rd_ptr[AW-1:0]]};
      else if (hb_emit) out_data_q <= {HB_MAGIC, DEG_DATA_WIDTH'(cyc)};

      if (emit) begin
        emit_cnt_q <= emit_cnt_q + 32'd1;
        gap_cnt    <= GAP_LOAD;
        idle_cnt   <= '0;
      end else begin
        if (gap_cnt != '0)       gap_cnt  <= gap_cnt - 1'b1;
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign bus.out_enable = out_en_q;
  assign bus.out_data   = out_data_q;
  assign bus.emit_count = emit_cnt_q;
endmodule

// File: tb/tb_deg_out_packer.sv
// Directed bench: three packer instances (plain, gap=2, heartbeat=10) on one clock.
module tb_deg_out_packer;
  logic clock = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  deg_out_if #(.DEG_DATA_WIDTH(64), .MAGIC_NUM_WIDTH(16)) if_a ();
  deg_out_if #(.DEG_DATA_WIDTH(64), .MAGIC_NUM_WIDTH(16)) if_b ();
  deg_out_if #(.DEG_DATA_WIDTH(64), .MAGIC_NUM_WIDTH(16)) if_c ();

  deg_out_packer #(.DEPTH(4), .GAP_CYCLES(0), .HEARTBEAT(0))  u_a (.clock(clock), .reset(rst_a), .bus(if_a.slave));
  deg_out_packer #(.DEPTH(4), .GAP_CYCLES(2), .HEARTBEAT(0))  u_b (.clock(clock), .reset(rst_b), .bus(if_b.slave));
  deg_out_packer #(.DEPTH(4), .GAP_CYCLES(0), .HEARTBEAT(10)) u_c (.clock(clock), .reset(rst_c), .bus(if_c.slave));

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] q[$];
    logic [63:0] v;
    logic [79:0] last_c;
    int sent, pulses, last, hb_n;
    bit saw_full;

    if_a.in_valid = 0; if_a.in_data = '0;
    if_b.in_valid = 0; if_b.in_data = '0;
    if_c.in_valid = 0; if_c.in_data = '0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state
    chk("rst_ready_low", 96'(if_a.in_ready), 96'(0));
    chk("rst_oen",       96'(if_a.out_enable), 96'(0));
    chk("rst_odata",     96'(if_a.out_data), 96'(0));
    chk("rst_count",     96'(if_a.emit_count), 96'(0));
    rst_a = 0; rst_b = 0;
    #1 chk("ready_after_rst", 96'(if_a.in_ready), 96'(1));

    // Single record, accepted on the first edge after reset
    if_a.in_valid = 1; if_a.in_data = 64'h1234;
    step();
    if_a.in_valid = 0;
    chk("single_not_yet", 96'(if_a.out_enable), 96'(0));
    step();
    chk("single_oen",   96'(if_a.out_enable), 96'(1));
    chk("single_data",  96'(if_a.out_data), 96'({16'hDE60, 64'h1234}));
    chk("single_count", 96'(if_a.emit_count), 96'(1));
    step();
    chk("single_pulse_end", 96'(if_a.out_enable), 96'(0));
    chk("single_hold",      96'(if_a.out_data), 96'({16'hDE60, 64'h1234}));

    // Burst of 8 with no gap: pulse j visible two iterations after its push
    for (int c = 0; c <= 10; c++) begin
      int e;
      if_a.in_valid = (c < 8);
      if_a.in_data  = 64'hA000 + 64'(c);
      if (c < 8) chk("burst_ready", 96'(if_a.in_ready), 96'(1));
      chk("burst_oen", 96'(if_a.out_enable), 96'((c >= 2 && c <= 9) ? 1 : 0));
      if (c >= 2 && c <= 9) begin
        v = 64'hA000 + 64'(c - 2);
        chk("burst_data", 96'(if_a.out_data), 96'({16'hDE60, v}));
      end
      e = (c < 1) ? 0 : ((c - 1 > 8) ? 8 : c - 1);
      chk("burst_count", 96'(if_a.emit_count), 96'(1 + e));
      step();
    end

    // Gap=2: hold in_valid until 7 records taken; pulses exactly 3 apart, FIFO fills
    sent = 0; pulses = 0; last = -1; saw_full = 0;
    for (int c = 0; c < 40; c++) begin
      if_b.in_valid = (sent < 7);
      if_b.in_data  = 64'hB000 + 64'(sent);
      if (if_b.out_enable) begin
        pulses++;
        if (q.size() > 0) begin
          v = q.pop_front();
          chk("gap_data", 96'(if_b.out_data), 96'({16'hDE60, v}));
        end else chk("gap_unexpected_pulse", 96'(1), 96'(0));
        if (last >= 0) chk("gap_spacing", 96'(c - last), 96'(3));
        last = c;
      end
      if (if_b.in_valid && !if_b.in_ready) saw_full = 1;
      if (if_b.in_valid && if_b.in_ready) begin
        q.push_back(if_b.in_data);
        sent++;
      end
      step();
    end
    if_b.in_valid = 0;
    chk("gap_pulses",    96'(pulses), 96'(7));
    chk("gap_saw_full",  96'(saw_full), 96'(1));
    chk("gap_count",     96'(if_b.emit_count), 96'(7));
    chk("gap_drained",   96'(q.size()), 96'(0));

    // Reset mid-stream: 4 pushed, first emitted, 3 left buffered, then reset
    for (int c = 0; c < 4; c++) begin
      if_b.in_valid = 1;
      if_b.in_data  = 64'hD000 + 64'(c);
      step();
    end
    if_b.in_valid = 1;
    rst_b = 1;
    #1 chk("midrst_ready_low", 96'(if_b.in_ready), 96'(0));
    step();
    rst_b = 0; if_b.in_valid = 0;
    #1;
    chk("midrst_oen",   96'(if_b.out_enable), 96'(0));
    chk("midrst_count", 96'(if_b.emit_count), 96'(0));
    chk("midrst_data",  96'(if_b.out_data), 96'(0));
    chk("midrst_ready", 96'(if_b.in_ready), 96'(1));
    for (int c = 0; c < 8; c++) begin
      step();
      chk("midrst_no_pulse", 96'(if_b.out_enable), 96'(0));
    end

    // Heartbeat=10: pulses at 11, 22, 33 cycles after reset, payload = cyc at the edge
    step();
    rst_c = 0;
    last_c = '0; hb_n = 0;
    for (int c = 1; c <= 34; c++) begin
      bit ex;
      step();
      ex = (c == 11 || c == 22 || c == 33);
      chk("hb_oen", 96'(if_c.out_enable), 96'(ex));
      if (ex) begin
        hb_n++;
        v = 64'(c - 1);
        last_c = {16'hDEB0, v};
      end
      chk("hb_data",  96'(if_c.out_data), 96'(last_c));
      chk("hb_count", 96'(if_c.emit_count), 96'(hb_n));
    end

    // Wrap: random in_valid over 12 records through the depth-4 FIFO
    q.delete(); sent = 0;
    for (int c = 0; c < 80; c++) begin
      if_a.in_valid = (sent < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      if_a.in_data  = 64'hC000 + 64'(sent);
      if (if_a.out_enable) begin
        if (q.size() > 0) begin
          v = q.pop_front();
          chk("wrap_data", 96'(if_a.out_data), 96'({16'hDE60, v}));
        end else chk("wrap_unexpected_pulse", 96'(1), 96'(0));
      end
      if (if_a.in_valid && if_a.in_ready) begin
        q.push_back(if_a.in_data);
        sent++;
      end
      step();
    end
    if_a.in_valid = 0;
    chk("wrap_drained", 96'(q.size()), 96'(0));
    chk("wrap_count",   96'(if_a.emit_count), 96'(9 + sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
